global_fsm_ctrl: RTL and testbench

GLOBAL_FSM_CTRL -- requirements
Module: global_fsm_ctrl

---
 rtl/global_fsm_ctrl_if.sv | 28 ++
 rtl/global_fsm_ctrl.sv | 99 +++++++++
 tb/tb_global_fsm_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/global_fsm_ctrl_if.sv
// Host handshake, task-done inputs and broadcast outputs of the global run controller.
interface global_fsm_ctrl_if #(
   parameter int NUM_TASKS = 4,
   parameter int SCALAR_W  = 32
);
   logic                 ap_start;
   logic                 ap_ready;
   logic                 ap_done;
   logic                 ap_idle;
   logic [SCALAR_W-1:0]  s_seq_len;
   logic [SCALAR_W-1:0]  global_fsm_s_seq_len;
   logic                 global_fsm_ap_start;
   logic                 global_fsm_ap_done;
   logic [NUM_TASKS-1:0] task_is_done;
   logic [31:0]          run_cycles;

   modport master (
      output ap_start, s_seq_len, task_is_done,
      input  ap_ready, ap_done, ap_idle, global_fsm_s_seq_len,
             global_fsm_ap_start, global_fsm_ap_done, run_cycles
   );

   modport slave (
      input  ap_start, s_seq_len, task_is_done,
      output ap_ready, ap_done, ap_idle, global_fsm_s_seq_len,
             global_fsm_ap_start, global_fsm_ap_done, run_cycles
   );
endinterface

// File: rtl/global_fsm_ctrl.sv
// Global run controller: start accepted in IDLE, LAUNCH 1 cycle, RUN until all tasks done, FINISH 1 cycle; no backpressure.
// Registered outputs; run_cycles is live only when GLOBAL_FSM_CYCLE_COUNT_EN is defined, otherwise tied to 0.
module global_fsm_ctrl #(
   parameter int NUM_TASKS = 4,
   parameter int SCALAR_W  = 32
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   global_fsm_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 ready_nxt;
   logic                 done_nxt;
   logic                 idle_nxt;
   logic                 ready_q;
   logic                 done_q;
   logic                 idle_q;
   logic [SCALAR_W-1:0]  seq_len_q;
   logic [NUM_TASKS-1:0] task_done;
   logic                 all_done;
   logic                 start_acc;

   assign task_done = bus.task_is_done;
   // Only the same-cycle AND of every task counts; earlier partial completions are not latched.
   assign all_done  = &task_done;
   assign start_acc = (state == IDLE) && bus.ap_start;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.ap_start) state_nxt = LAUNCH;
         LAUNCH:  state_nxt = RUN;
         RUN:     if (all_done) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      ready_nxt = (state_nxt == LAUNCH);
      done_nxt  = (state_nxt == FINISH);
      idle_nxt  = (state_nxt == IDLE);
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state     <= IDLE;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         idle_q    <= 1'b1;
         seq_len_q <= '0;
      end else begin
         state   <= state_nxt;
         ready_q <= ready_nxt;
         done_q  <= done_nxt;
         idle_q  <= idle_nxt;
         if (start_acc) begin
            seq_len_q <= bus.s_seq_len;
         end
      end
   end

   assign bus.ap_ready             = ready_q;
   assign bus.ap_done              = done_q;
   assign bus.ap_idle              = idle_q;
   assign bus.global_fsm_ap_start  = ready_q;
   assign bus.global_fsm_ap_done   = done_q;
   assign bus.global_fsm_s_seq_len = seq_len_q;

`ifdef GLOBAL_FSM_CYCLE_COUNT_EN
   logic [31:0] cyc_cnt;
   logic [31:0] cyc_cnt_inc;
   logic [31:0] run_cycles_q;

   assign cyc_cnt_inc = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;

   // The snapshot includes the final RUN cycle, so it takes the incremented value.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         cyc_cnt      <= '0;
         run_cycles_q <= '0;
      end else begin
         if (start_acc) begin
            cyc_cnt <= '0;
         end else if (state == LAUNCH || state == RUN) begin
            cyc_cnt <= cyc_cnt_inc;
         end
         if (state == RUN && all_done) begin
            run_cycles_q <= cyc_cnt_inc;
         end
      end
   end

   assign bus.run_cycles = run_cycles_q;
`else
   assign bus.run_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_global_fsm_ctrl.sv
// Scoreboard bench for global_fsm_ctrl: an event-level model queues expected ready/done pulses per cycle.
module tb_global_fsm_ctrl;
   localparam int NT = 4;
   localparam logic [NT-1:0] ALL = '1;
`ifdef GLOBAL_FSM_CYCLE_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic ap_clk = 1'b0;
   logic ap_rst_n;
   always #5 ap_clk = ~ap_clk;

   global_fsm_ctrl_if #(.NUM_TASKS(NT), .SCALAR_W(32)) bus ();

   global_fsm_ctrl #(.NUM_TASKS(NT), .SCALAR_W(32)) dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .bus      (bus)
   );

   typedef struct { bit is_done; int cyc; logic [31:0] seq; logic [31:0] rc; } ev_t;
   typedef struct { bit idle; logic [31:0] seq; logic [31:0] rc; } st_t;

   ev_t eq[$];
   st_t exp_tab[int];
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   bit  in_rst = 1'b1;
   int  obs_ready = -1;
   int  obs_done = -1;
   logic [31:0] obs_rc = '0;

   // Reference model: a run occupies [accept, done+1]; the first idle cycle after it is done+2.
   bit          m_run = 1'b0;
   int          m_acc = 0;
   int          m_free = 0;
   logic [31:0] m_seq = '0;
   logic [31:0] m_rc = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endtask

   task automatic model(input bit st, input logic [NT-1:0] td, input logic [31:0] ln);
      if (!m_run && cyc >= m_free && st) begin
         m_run = 1'b1;
         m_acc = cyc;
         m_seq = ln;
         eq.push_back('{is_done: 1'b0, cyc: cyc + 1, seq: ln, rc: m_rc});
      end else if (m_run && cyc >= m_acc + 2 && td == ALL) begin
         m_run  = 1'b0;
         m_free = cyc + 2;
         if (CNT_EN) m_rc = 32'(cyc - m_acc);
         eq.push_back('{is_done: 1'b1, cyc: cyc + 1, seq: m_seq, rc: m_rc});
      end
      exp_tab[cyc + 1] = '{idle: (!m_run && (cyc + 1 >= m_free)), seq: m_seq, rc: m_rc};
   endtask

   task automatic step(input bit st, input logic [NT-1:0] td, input logic [31:0] ln);
      bus.ap_start     = st;
      bus.task_is_done = td;
      bus.s_seq_len    = ln;
      model(st, td, ln);
      @(posedge ap_clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      in_rst           = 1'b1;
      ap_rst_n         = 1'b0;
      bus.ap_start     = 1'b0;
      bus.task_is_done = '0;
      #1;
      chk("rst_idle",     bus.ap_idle, 1);
      chk("rst_ready",    bus.ap_ready, 0);
      chk("rst_done",     bus.ap_done, 0);
      chk("rst_gstart",   bus.global_fsm_ap_start, 0);
      chk("rst_gdone",    bus.global_fsm_ap_done, 0);
      chk("rst_seq",      bus.global_fsm_s_seq_len, 0);
      chk("rst_runcyc",   bus.run_cycles, 0);
      eq.delete();
      m_run = 1'b0;
      m_seq = '0;
      m_rc  = '0;
      repeat (2) begin
         @(posedge ap_clk);
         cyc++;
      end
      #1;
      ap_rst_n = 1'b1;
      m_free   = cyc;
      exp_tab[cyc] = '{idle: 1'b1, seq: 32'd0, rc: 32'd0};
      in_rst = 1'b0;
   endtask

   ev_t mon_e;
   always @(negedge ap_clk) begin
      if (!in_rst) begin
         while (eq.size() > 0 && eq[0].cyc < cyc) begin
            chk(eq[0].is_done ? "missed_done" : "missed_ready", 0, 1);
            void'(eq.pop_front());
         end
         if (bus.ap_ready || bus.ap_done) begin
            if (eq.size() == 0) begin
               chk("spurious_pulse", {30'd0, bus.ap_ready, bus.ap_done}, 0);
            end else begin
               mon_e = eq.pop_front();
               chk(mon_e.is_done ? "done_cycle" : "ready_cycle", cyc, mon_e.cyc);
               chk("ap_done_kind",  bus.ap_done, mon_e.is_done);
               chk("ap_ready_kind", bus.ap_ready, !mon_e.is_done);
               chk("gstart_pulse",  bus.global_fsm_ap_start, !mon_e.is_done);
               chk("gdone_pulse",   bus.global_fsm_ap_done, mon_e.is_done);
               if (mon_e.is_done) chk("done_seq", bus.global_fsm_s_seq_len, mon_e.seq);
            end
         end else begin
            chk("bcast_quiet", {30'd0, bus.global_fsm_ap_start, bus.global_fsm_ap_done}, 0);
         end
         if (exp_tab.exists(cyc)) begin
            chk("ap_idle",    bus.ap_idle, exp_tab[cyc].idle);
            chk("seq_len",    bus.global_fsm_s_seq_len, exp_tab[cyc].seq);
            chk("run_cycles", bus.run_cycles, exp_tab[cyc].rc);
            exp_tab.delete(cyc);
         end
         if (bus.ap_ready) obs_ready = cyc;
         if (bus.ap_done) begin
            obs_done = cyc;
            obs_rc   = bus.run_cycles;
         end
      end
   end

   initial begin
      int s;
      int done1;
      bit st;
      logic [NT-1:0] td;

      ap_rst_n         = 1'b1;
      bus.ap_start     = 1'b0;
      bus.task_is_done = '0;
      bus.s_seq_len    = '0;
      #2;
      do_reset();

      // Basic run: all tasks done from cycle 5, scalar changes after launch.
      s = cyc;
      step(1'b1, '0, 32'd128);
      repeat (4) step(1'b0, '0, $urandom);
      step(1'b0, ALL, $urandom);
      repeat (3) step(1'b0, '0, $urandom);
      chk("basic_ready_lat", 32'(obs_ready - s), 1);
      chk("basic_done_lat",  32'(obs_done - s), 6);
      chk("basic_seq",       bus.global_fsm_s_seq_len, 128);
      chk("basic_run_cycles", obs_rc, CNT_EN ? 32'd5 : 32'd0);

      // Walking partial completions with ignored start pulses.
      s = cyc;
      step(1'b1, '0, 32'd77);
      for (int i = 1; i < 10; i++) begin
         td = (i < 4) ? 4'h1 : ((i < 7) ? 4'h3 : 4'h7);
         step(1'($urandom_range(0, 1)), td, $urandom);
      end
      step(1'b0, ALL, $urandom);
      repeat (3) step(1'b0, '0, $urandom);
      chk("walk_done_lat", 32'(obs_done - s), 11);

      // Dropping completions are not remembered.
      s = cyc;
      step(1'b1, '0, 32'd9);
      step(1'b0, 4'h7, 32'd1);
      step(1'b0, 4'h7, 32'd2);
      step(1'b1, 4'h0, 32'd3);
      step(1'b0, 4'h0, 32'd4);
      step(1'b0, ALL, 32'd5);
      repeat (3) step(1'b0, '0, 32'd6);
      chk("drop_done_lat", 32'(obs_done - s), 6);
      chk("drop_seq", bus.global_fsm_s_seq_len, 9);

      // Start held across two runs: one IDLE cycle between FINISH and LAUNCH.
      step(1'b1, '0, 32'd21);
      step(1'b1, '0, 32'd22);
      step(1'b1, ALL, 32'd23);
      step(1'b1, '0, 32'd24);
      done1 = obs_done;
      step(1'b1, '0, 32'd25);
      step(1'b0, '0, 32'd26);
      chk("b2b_gap", 32'(obs_ready - done1), 2);
      step(1'b0, ALL, 32'd27);
      repeat (2) step(1'b0, '0, 32'd0);
      chk("b2b_seq", bus.global_fsm_s_seq_len, 25);

      // Reset in the middle of RUN, then a minimum-latency run.
      step(1'b1, '0, 32'd55);
      repeat (4) step(1'b0, '0, 32'd0);
      do_reset();
      s = cyc;
      step(1'b1, '0, 32'd66);
      step(1'b0, ALL, 32'd0);
      step(1'b0, ALL, 32'd0);
      repeat (2) step(1'b0, '0, 32'd0);
      chk("min_done_lat", 32'(obs_done - s), 3);
      chk("min_run_cycles", obs_rc, CNT_EN ? 32'd2 : 32'd0);

      // Randomized traffic with occasional resets.
      repeat (2500) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         st = ($urandom_range(0, 2) == 0);
         td = ($urandom_range(0, 3) == 0) ? ALL : NT'($urandom);
         step(st, td, $urandom);
      end
      repeat (3) step(1'b0, ALL, 32'd0);
      repeat (3) step(1'b0, '0, 32'd0);
      chk("queue_drained", eq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
